// File: rtl/prog_counter.sv
// Runtime-programmable modulus counter with sync clear/load, one-shot halt and
// a run-time modulus register. Define PCNT_DOWN_EN to add the DIR port and down-counting.
module prog_counter #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ENABLE,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             MOD_WE,
  input  logic [WIDTH-1:0] MOD_VAL,
  input  logic             ONESHOT,
`ifdef PCNT_DOWN_EN
  input  logic             DIR,
`endif
  output logic [WIDTH-1:0] COUNT,
  output logic [WIDTH-1:0] MODULUS,
  output logic             TC,
  output logic             DONE
);

  // DEFAULT_MOD = 2^WIDTH truncates to 0; M-1 then wraps to all-ones, which is
  // exactly the full-range terminal value.
  localparam logic [WIDTH-1:0] RST_MOD = WIDTH'(DEFAULT_MOD);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q,   mod_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] mod_m1;
  logic             terminal;
  logic [WIDTH-1:0] step_val;
  logic             tc;

  assign mod_m1 = mod_q - WIDTH'(1);

  // Next value of an enabled step and whether that step is the terminal one.
  always_comb begin
    terminal = 1'b0;
    step_val = count_q;
`ifdef PCNT_DOWN_EN
    if (DIR) begin
      terminal = (count_q == '0);
      if (terminal || (count_q > mod_m1)) step_val = mod_m1;
      else                                step_val = count_q - WIDTH'(1);
    end else
`endif
    begin
      // >= also recovers a count stranded above a freshly shrunk modulus
      terminal = (count_q >= mod_m1);
      step_val = terminal ? '0 : count_q + WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mod_d   = mod_q;
    done_d  = done_q;
    tc      = 1'b0;

    if (MOD_WE && (MOD_VAL != '0)) mod_d = MOD_VAL;

    if (CLR) begin
      count_d = '0;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (LOAD) begin
      count_d = (LOAD_VAL > mod_m1) ? mod_m1 : LOAD_VAL;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (ENABLE && (state_q == ST_RUN)) begin
      count_d = step_val;
      tc      = terminal;
      if (terminal && ONESHOT) begin
        state_d = ST_HALT;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_RUN;
      count_q <= '0;
      mod_q   <= RST_MOD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mod_q   <= mod_d;
      done_q  <= done_d;
    end
  end

  assign COUNT   = count_q;
  assign MODULUS = mod_q;
  assign TC      = tc;
  assign DONE    = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed test bench for prog_counter (WIDTH=8, DEFAULT_MOD=16).
module tb_prog_counter;

  logic       CLK, RST_n, ENABLE, CLR, LOAD, MOD_WE, ONESHOT;
  logic [7:0] LOAD_VAL, MOD_VAL;
`ifdef PCNT_DOWN_EN
  logic       DIR;
`endif
  logic [7:0] COUNT, MODULUS;
  logic       TC, DONE;

  int tests = 0;
  int fails = 0;

  prog_counter #(.WIDTH(8), .DEFAULT_MOD(16)) dut (
    .CLK(CLK), .RST_n(RST_n), .ENABLE(ENABLE), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .MOD_WE(MOD_WE), .MOD_VAL(MOD_VAL), .ONESHOT(ONESHOT),
`ifdef PCNT_DOWN_EN
    .DIR(DIR),
`endif
    .COUNT(COUNT), .MODULUS(MODULUS), .TC(TC), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs are set just after a falling edge; this crosses one rising edge.
  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    ENABLE = 0; CLR = 0; LOAD = 0; MOD_WE = 0; LOAD_VAL = 0; MOD_VAL = 0;
  endtask

  task automatic write_mod(input logic [7:0] m);
    idle(); MOD_WE = 1; MOD_VAL = m;
    next_cycle(); idle();
  endtask

  task automatic do_load(input logic [7:0] v);
    idle(); LOAD = 1; LOAD_VAL = v;
    next_cycle(); idle();
  endtask

  task automatic test_reset();
    idle(); ONESHOT = 0;
`ifdef PCNT_DOWN_EN
    DIR = 0;
`endif
    RST_n = 0;
    repeat (2) next_cycle();
    RST_n = 1;
    next_cycle();
    #1;
    tests++; if (COUNT !== 8'd0)    begin fails++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    tests++; if (MODULUS !== 8'd16) begin fails++; $display("FAIL reset_mod got %0d exp 16", MODULUS); end
    tests++; if (DONE !== 1'b0)     begin fails++; $display("FAIL reset_done got %b exp 0", DONE); end
    tests++; if (TC !== 1'b0)       begin fails++; $display("FAIL reset_tc got %b exp 0", TC); end
  endtask

  task automatic test_free_run();
    idle(); ENABLE = 1;
    for (int i = 0; i < 18; i++) begin
      #1;
      tests++; if (COUNT !== 8'(i % 16)) begin fails++; $display("FAIL free_count i=%0d got %0d exp %0d", i, COUNT, i % 16); end
      tests++; if (TC !== ((i % 16) == 15)) begin fails++; $display("FAIL free_tc i=%0d got %b exp %b", i, TC, (i % 16) == 15); end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL free_done i=%0d got %b exp 0", i, DONE); end
      next_cycle();
    end
    idle(); CLR = 1; next_cycle(); idle();
  endtask

  task automatic test_oneshot();
    ONESHOT = 1;
    write_mod(8'd5);
    #1;
    tests++; if (MODULUS !== 8'd5) begin fails++; $display("FAIL os_mod got %0d exp 5", MODULUS); end
    ENABLE = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (COUNT !== 8'(i)) begin fails++; $display("FAIL os_count i=%0d got %0d exp %0d", i, COUNT, i); end
      tests++; if (TC !== (i == 4)) begin fails++; $display("FAIL os_tc i=%0d got %b exp %b", i, TC, i == 4); end
      next_cycle();
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++; if (COUNT !== 8'd0) begin fails++; $display("FAIL halt_count i=%0d got %0d exp 0", i, COUNT); end
      tests++; if (DONE !== 1'b1)  begin fails++; $display("FAIL halt_done i=%0d got %b exp 1", i, DONE); end
      tests++; if (TC !== 1'b0)    begin fails++; $display("FAIL halt_tc i=%0d got %b exp 0", i, TC); end
      if (i == 5) ONESHOT = 0;
      next_cycle();
    end
    LOAD = 1; LOAD_VAL = 8'd2;
    #1;
    tests++; if (TC !== 1'b0) begin fails++; $display("FAIL os_load_tc got %b exp 0", TC); end
    next_cycle();
    LOAD = 0;
    #1;
    tests++; if (COUNT !== 8'd2) begin fails++; $display("FAIL os_load_count got %0d exp 2", COUNT); end
    tests++; if (DONE !== 1'b0)  begin fails++; $display("FAIL os_load_done got %b exp 0", DONE); end
    next_cycle();
    tests++; if (COUNT !== 8'd3) begin fails++; $display("FAIL os_resume got %0d exp 3", COUNT); end
    idle(); ONESHOT = 0;
    CLR = 1; next_cycle(); idle();
  endtask

  task automatic test_mod_shrink();
    write_mod(8'd16);
    do_load(8'd12);
    write_mod(8'd8);
    #1;
    tests++; if (MODULUS !== 8'd8) begin fails++; $display("FAIL shrink_mod got %0d exp 8", MODULUS); end
    tests++; if (COUNT !== 8'd12)  begin fails++; $display("FAIL shrink_hold got %0d exp 12", COUNT); end
    ENABLE = 1;
    #1;
    tests++; if (TC !== 1'b1) begin fails++; $display("FAIL shrink_tc got %b exp 1", TC); end
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd0) begin fails++; $display("FAIL shrink_wrap got %0d exp 0", COUNT); end
    write_mod(8'd0);
    tests++; if (MODULUS !== 8'd8) begin fails++; $display("FAIL mod_zero got %0d exp 8", MODULUS); end
    // modulus write in the same cycle as a step: the step uses the old M
    do_load(8'd6);
    ENABLE = 1; MOD_WE = 1; MOD_VAL = 8'd4;
    #1;
    tests++; if (TC !== 1'b0) begin fails++; $display("FAIL old_m_tc got %b exp 0", TC); end
    next_cycle(); MOD_WE = 0;
    #1;
    tests++; if (COUNT !== 8'd7)   begin fails++; $display("FAIL old_m_count got %0d exp 7", COUNT); end
    tests++; if (MODULUS !== 8'd4) begin fails++; $display("FAIL new_m got %0d exp 4", MODULUS); end
    tests++; if (TC !== 1'b1)      begin fails++; $display("FAIL new_m_tc got %b exp 1", TC); end
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd0) begin fails++; $display("FAIL new_m_wrap got %0d exp 0", COUNT); end
  endtask

  task automatic test_priority();
    write_mod(8'd8);
    do_load(8'd3);
    CLR = 1; LOAD = 1; LOAD_VAL = 8'd7; ENABLE = 1;
    #1;
    tests++; if (TC !== 1'b0) begin fails++; $display("FAIL prio_tc got %b exp 0", TC); end
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd0) begin fails++; $display("FAIL prio_clr got %0d exp 0", COUNT); end
    LOAD = 1; LOAD_VAL = 8'd5; ENABLE = 1;
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd5) begin fails++; $display("FAIL load_over_en got %0d exp 5", COUNT); end
    do_load(8'd20);
    tests++; if (COUNT !== 8'd7) begin fails++; $display("FAIL load_clamp got %0d exp 7", COUNT); end
  endtask

  task automatic test_mod_one();
    write_mod(8'd1);
    CLR = 1; next_cycle(); idle();
    ENABLE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (COUNT !== 8'd0) begin fails++; $display("FAIL m1_count i=%0d got %0d exp 0", i, COUNT); end
      tests++; if (TC !== 1'b1)    begin fails++; $display("FAIL m1_tc i=%0d got %b exp 1", i, TC); end
      next_cycle();
    end
    idle();
  endtask

`ifdef PCNT_DOWN_EN
  task automatic test_down();
    logic [7:0] exp_c [4];
    logic       exp_t [4];
    exp_c = '{8'd2, 8'd1, 8'd0, 8'd5};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    write_mod(8'd6);
    do_load(8'd2);
    DIR = 1; ENABLE = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (COUNT !== exp_c[i]) begin fails++; $display("FAIL down_count i=%0d got %0d exp %0d", i, COUNT, exp_c[i]); end
      tests++; if (TC !== exp_t[i])    begin fails++; $display("FAIL down_tc i=%0d got %b exp %b", i, TC, exp_t[i]); end
      next_cycle();
    end
    idle();
    write_mod(8'd3);
    ENABLE = 1;
    #1;
    tests++; if (TC !== 1'b0) begin fails++; $display("FAIL down_oor_tc got %b exp 0", TC); end
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd2) begin fails++; $display("FAIL down_oor got %0d exp 2", COUNT); end
    DIR = 0;
  endtask
`endif

  task automatic test_async_reset();
    write_mod(8'd12);
    CLR = 1; next_cycle(); idle();
    ENABLE = 1;
    repeat (9) next_cycle();
    idle();
    tests++; if (COUNT !== 8'd9) begin fails++; $display("FAIL pre_rst_count got %0d exp 9", COUNT); end
    RST_n = 0;
    #1;
    tests++; if (COUNT !== 8'd0)    begin fails++; $display("FAIL async_count got %0d exp 0", COUNT); end
    tests++; if (MODULUS !== 8'd16) begin fails++; $display("FAIL async_mod got %0d exp 16", MODULUS); end
    tests++; if (DONE !== 1'b0)     begin fails++; $display("FAIL async_done got %b exp 0", DONE); end
    next_cycle();
    RST_n = 1;
    next_cycle();
    ENABLE = 1;
    next_cycle(); idle();
    tests++; if (COUNT !== 8'd1) begin fails++; $display("FAIL post_rst_count got %0d exp 1", COUNT); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_oneshot();
    test_mod_shrink();
    test_priority();
    test_mod_one();
`ifdef PCNT_DOWN_EN
    test_down();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
